// File: rtl/uart_fifo_pacer_pkg.sv
// Shared types for the FIFO-to-UART drain stage: FSM state encoding and
// latency-counter sizing, decodable by debug probes elsewhere.
package uart_fifo_pacer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARM       = 3'd1,
    ST_WAIT_DATA = 3'd2,
    ST_SEND      = 3'd3,
    ST_HOLD      = 3'd4
  } state_e;

  // READ_LATENCY is limited to 1..3, so the remaining-cycles counter fits in 2 bits.
  localparam int LAT_W = 2;

  function automatic logic is_busy(input state_e s);
    return (s == ST_WAIT_DATA) || (s == ST_SEND) || (s == ST_HOLD);
  endfunction

endpackage

// File: rtl/uart_fifo_pacer_pace_timer.sv
// Loadable down-counter that saturates at zero and flags when it gets there.
// The load cycle itself counts as the first elapsed cycle of the interval.
module pace_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      // Interval N lets the zero flag rise N cycles after the load cycle.
      cnt_d = (load_val_i == '0) ? '0 : load_val_i - W'(1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/uart_fifo_pacer.sv
// Drains a single-port byte FIFO into a UART transmitter, one paced byte at a
// time, hiding the FIFO read latency behind a registered tx_data/tx_strobe pair.
module uart_fifo_pacer
  import uart_fifo_pacer_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int INTERVAL_W   = 24,
  parameter int COUNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [INTERVAL_W-1:0] interval,
  input  logic                  fifo_available,
  input  logic                  fifo_write_pending,
  input  logic [7:0]            fifo_read_data,
  output logic                  fifo_read_strobe,
  input  logic                  tx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_strobe,
  output logic                  busy,
  output logic [COUNT_W-1:0]    sent_count
);

  state_e             state_q, state_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic               pace_zero;
  logic               pace_load;
  logic               capture;

  logic [7:0]         tx_data_q;
  logic               tx_strobe_q;
  logic               busy_q;
  logic [COUNT_W-1:0] sent_count_q;

  pace_timer #(
    .W(INTERVAL_W)
  ) u_pace_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_i    (pace_load),
    .load_val_i(interval),
    .zero_o    (pace_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (fifo_read_strobe) begin
          state_d = ST_WAIT_DATA;
          lat_d   = LAT_W'(READ_LATENCY - 1);
        end
      end
      ST_WAIT_DATA: begin
        if (lat_q == '0) state_d = ST_SEND;
        else             lat_d   = lat_q - LAT_W'(1);
      end
      ST_SEND: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        // tx_ready may still show idle this cycle even though a byte was just handed over.
        state_d = enable ? ST_ARM : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    fifo_read_strobe = (state_q == ST_ARM) && enable && fifo_available && tx_ready
                       && !fifo_write_pending && pace_zero;
    capture          = (state_q == ST_WAIT_DATA) && (lat_q == '0);
    pace_load        = (state_q == ST_SEND);
  end

  // Outputs registered off the next state so tx_strobe and busy line up with SEND/busy states.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_data_q    <= '0;
      tx_strobe_q  <= 1'b0;
      busy_q       <= 1'b0;
      sent_count_q <= '0;
    end else begin
      tx_strobe_q <= (state_d == ST_SEND);
      busy_q      <= is_busy(state_d);
      if (capture) begin
        tx_data_q <= fifo_read_data;
      end
      if (state_d == ST_SEND) begin
        sent_count_q <= sent_count_q + COUNT_W'(1);
      end
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_strobe  = tx_strobe_q;
  assign busy       = busy_q;
  assign sent_count = sent_count_q;

endmodule

// File: tb/tb_uart_fifo_pacer.sv
// Directed bench: dut_a uses READ_LATENCY=1, COUNT_W=4; dut_b uses READ_LATENCY=2.
// Inputs change on the falling edge, outputs are sampled 1 ns later.
module tb_uart_fifo_pacer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [23:0] interval = '0;
  logic        wp = 1'b0;
  logic        tx_ready = 1'b0;

  logic        a_en = 1'b0, a_avail = 1'b0;
  logic [7:0]  a_data = '0;
  logic        a_rs, a_txs, a_busy;
  logic [7:0]  a_txd;
  logic [3:0]  a_cnt;

  logic        b_en = 1'b0, b_avail = 1'b0;
  logic [7:0]  b_data = '0;
  logic        b_rs, b_txs, b_busy;
  logic [7:0]  b_txd;
  logic [15:0] b_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  uart_fifo_pacer #(.READ_LATENCY(1), .INTERVAL_W(24), .COUNT_W(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .enable(a_en), .interval(interval),
    .fifo_available(a_avail), .fifo_write_pending(wp), .fifo_read_data(a_data),
    .fifo_read_strobe(a_rs), .tx_ready(tx_ready), .tx_data(a_txd),
    .tx_strobe(a_txs), .busy(a_busy), .sent_count(a_cnt)
  );

  uart_fifo_pacer #(.READ_LATENCY(2), .INTERVAL_W(24), .COUNT_W(16)) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(b_en), .interval(interval),
    .fifo_available(b_avail), .fifo_write_pending(wp), .fifo_read_data(b_data),
    .fifo_read_strobe(b_rs), .tx_ready(tx_ready), .tx_data(b_txd),
    .tx_strobe(b_txs), .busy(b_busy), .sent_count(b_cnt)
  );

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a_en = i[0]; b_en = ~i[0]; a_avail = 1'b1; b_avail = 1'b1;
      wp = i[1]; tx_ready = 1'b1; a_data = 8'hFF; b_data = 8'hEE; interval = 24'd3;
      #1;
      total++;
      if ({a_rs, a_txs, a_busy, a_txd, a_cnt} !== 15'd0) begin
        bad++;
        $display("FAIL reset_a: rs=%b txs=%b busy=%b txd=%h cnt=%h, required all 0", a_rs, a_txs, a_busy, a_txd, a_cnt);
      end
      total++;
      if ({b_rs, b_txs, b_busy, b_txd, b_cnt} !== 27'd0) begin
        bad++;
        $display("FAIL reset_b: rs=%b txs=%b busy=%b txd=%h cnt=%h, required all 0", b_rs, b_txs, b_busy, b_txd, b_cnt);
      end
    end
    a_en = 1'b0; b_en = 1'b0; a_avail = 1'b0; b_avail = 1'b0; wp = 1'b0; interval = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    a_en = 1'b1; a_data = 8'h41; tx_ready = 1'b1; interval = '0;
    @(negedge clk);
    a_avail = 1'b1;
    #1;
    total++;
    if (a_rs !== 1'b1) begin bad++; $display("FAIL single_strobe_c0: rs=%b, required 1", a_rs); end
    @(negedge clk);
    a_avail = 1'b0;
    #1;
    total++;
    if ({a_rs, a_txs, a_busy} !== 3'b001) begin
      bad++; $display("FAIL single_c1: rs=%b txs=%b busy=%b, required 0 0 1", a_rs, a_txs, a_busy);
    end
    @(negedge clk);
    #1;
    $display("tx a byte=%h count=%0d", a_txd, a_cnt);
    total++;
    if ({a_txs, a_txd, a_cnt} !== {1'b1, 8'h41, 4'd1}) begin
      bad++; $display("FAIL single_c2: txs=%b txd=%h cnt=%0d, required 1 41 1", a_txs, a_txd, a_cnt);
    end
    @(negedge clk);
    a_en = 1'b0;
    #1;
    total++;
    if (a_txs !== 1'b0) begin bad++; $display("FAIL single_c3_strobe_width: txs=%b, required 0", a_txs); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_write_conflict();
    a_en = 1'b1; wp = 1'b1; a_avail = 1'b1; a_data = 8'h5A;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      total++;
      if (a_rs !== 1'b0) begin bad++; $display("FAIL conflict_c%0d: rs=%b, required 0", c, a_rs); end
      @(negedge clk);
    end
    wp = 1'b0;
    #1;
    total++;
    if (a_rs !== 1'b1) begin bad++; $display("FAIL conflict_c5: rs=%b, required 1", a_rs); end
    @(negedge clk);
    a_avail = 1'b0;
    @(negedge clk);
    #1;
    $display("tx a byte=%h count=%0d", a_txd, a_cnt);
    total++;
    if ({a_txs, a_txd, a_cnt} !== {1'b1, 8'h5A, 4'd2}) begin
      bad++; $display("FAIL conflict_send: txs=%b txd=%h cnt=%0d, required 1 5a 2", a_txs, a_txd, a_cnt);
    end
    a_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_pacing();
    logic [7:0] pb [3];
    int popped, sent, last;
    pb[0] = 8'h01; pb[1] = 8'h02; pb[2] = 8'h03;
    popped = 0; sent = 0; last = 0;
    interval = 24'd100; a_en = 1'b1; a_avail = 1'b1; a_data = pb[0];
    for (int cyc = 0; cyc < 400 && sent < 3; cyc++) begin
      @(negedge clk);
      a_avail = (popped < 3);
      if (popped > 0) a_data = pb[popped-1];
      #1;
      if (a_rs) popped++;
      if (a_txs) begin
        $display("tx a byte=%h count=%0d cycle=%0d", a_txd, a_cnt, cyc);
        total++;
        if (a_txd !== pb[sent]) begin bad++; $display("FAIL pacing_byte%0d: txd=%h, required %h", sent, a_txd, pb[sent]); end
        if (sent > 0) begin
          total++;
          if (cyc - last !== 102) begin bad++; $display("FAIL pacing_gap%0d: gap=%0d, required 102", sent, cyc - last); end
        end
        last = cyc;
        sent++;
      end
    end
    a_en = 1'b0;
    total++;
    if (sent !== 3) begin bad++; $display("FAIL pacing_timeout: sent=%0d, required 3", sent); end
    total++;
    if (popped !== 3) begin bad++; $display("FAIL pacing_reads: reads=%0d, required 3", popped); end
    total++;
    if (a_cnt !== 4'd5) begin bad++; $display("FAIL pacing_count: cnt=%0d, required 5", a_cnt); end
    @(negedge clk);
    a_avail = 1'b0;
    interval = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_enable_drop();
    int extra;
    b_en = 1'b1; b_data = 8'hC3;
    @(negedge clk);
    b_avail = 1'b1;
    #1;
    total++;
    if (b_rs !== 1'b1) begin bad++; $display("FAIL drop_strobe_c0: rs=%b, required 1", b_rs); end
    @(negedge clk);
    b_en = 1'b0;
    #1;
    total++;
    if (b_rs !== 1'b0) begin bad++; $display("FAIL drop_c1_rs: rs=%b, required 0", b_rs); end
    @(negedge clk);
    #1;
    total++;
    if (b_txs !== 1'b0) begin bad++; $display("FAIL drop_c2_early: txs=%b, required 0", b_txs); end
    @(negedge clk);
    #1;
    $display("tx b byte=%h count=%0d", b_txd, b_cnt);
    total++;
    if ({b_txs, b_txd, b_cnt} !== {1'b1, 8'hC3, 16'd1}) begin
      bad++; $display("FAIL drop_c3_send: txs=%b txd=%h cnt=%0d, required 1 c3 1", b_txs, b_txd, b_cnt);
    end
    extra = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      #1;
      if (b_rs || b_txs) extra++;
    end
    total++;
    if (extra !== 0) begin bad++; $display("FAIL drop_idle_reads: activity cycles=%0d, required 0", extra); end
    total++;
    if (b_busy !== 1'b0) begin bad++; $display("FAIL drop_idle_busy: busy=%b, required 0", b_busy); end
    b_avail = 1'b0;
  endtask

  task automatic test_abort();
    int strobes;
    b_en = 1'b1; b_avail = 1'b1; b_data = 8'h77;
    @(negedge clk);
    #1;
    total++;
    if (b_rs !== 1'b1) begin bad++; $display("FAIL abort_strobe: rs=%b, required 1", b_rs); end
    @(negedge clk);
    b_avail = 1'b0;
    reset_n = 1'b0;
    #1;
    total++;
    if ({b_busy, b_cnt, a_cnt} !== 21'd0) begin
      bad++; $display("FAIL abort_immediate: busy=%b cnt_b=%0d cnt_a=%0d, required 0 0 0", b_busy, b_cnt, a_cnt);
    end
    b_en = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    strobes = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      if (b_txs) strobes++;
    end
    total++;
    if (strobes !== 0 || b_cnt !== 16'd0 || b_txd !== 8'd0) begin
      bad++; $display("FAIL abort_no_send: strobes=%0d cnt=%0d txd=%h, required 0 0 00", strobes, b_cnt, b_txd);
    end
  endtask

  task automatic test_back_to_back_wrap();
    int sent, last;
    sent = 0; last = 0;
    interval = '0; a_en = 1'b1; a_avail = 1'b1; a_data = 8'h3C;
    for (int cyc = 0; cyc < 200 && sent < 16; cyc++) begin
      @(negedge clk);
      #1;
      if (a_txs) begin
        sent++;
        $display("tx a byte=%h count=%0d cycle=%0d", a_txd, a_cnt, cyc);
        if (sent > 1) begin
          total++;
          if (cyc - last !== 4) begin bad++; $display("FAIL b2b_gap%0d: gap=%0d, required 4", sent, cyc - last); end
        end
        if (sent == 15) begin
          total++;
          if (a_cnt !== 4'd15) begin bad++; $display("FAIL wrap_pre: cnt=%0d, required 15", a_cnt); end
        end
        if (sent == 16) begin
          total++;
          if (a_cnt !== 4'd0) begin bad++; $display("FAIL wrap: cnt=%0d, required 0", a_cnt); end
        end
        last = cyc;
      end
    end
    a_en = 1'b0;
    a_avail = 1'b0;
    total++;
    if (sent !== 16) begin bad++; $display("FAIL wrap_timeout: sent=%0d, required 16", sent); end
    total++;
    if (a_txd !== 8'h3C) begin bad++; $display("FAIL wrap_data: txd=%h, required 3c", a_txd); end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_write_conflict();
    test_pacing();
    test_enable_drop();
    test_abort();
    test_back_to_back_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/uart_fifo_pacer.md
# uart_fifo_pacer

Drain stage between the SPRAM-backed byte FIFO and the UART transmitter. Issues FIFO read strobes only when the transmitter is ready, the pacing interval has elapsed and no FIFO write is pending in the same cycle. Absorbs the FIFO read latency and presents one registered byte per `tx_strobe` to `uart_tx`. Replaces ad-hoc drain logic in top-level demos with one verified block.

## Interface
- `READ_LATENCY`, 1, cycles from `fifo_read_strobe` to valid `fifo_read_data`; legal values 1..3
- `INTERVAL_W`, 24, width of `interval`
- `COUNT_W`, 16, width of `sent_count`

- `clk`  in  1  system clock, 48 MHz in current designs
- `reset_n`  in  1  asynchronous, active-low reset
- `enable`  in  1  permit new reads; low finishes the in-flight byte, then idles
- `interval`  in  INTERVAL_W  minimum cycles from one `tx_strobe` to the next `fifo_read_strobe`; 0 = ready-limited only
- `fifo_available`  in  1  FIFO non-empty
- `fifo_write_pending`  in  1  FIFO write strobe this cycle; single-port RAM, so no read may coincide
- `fifo_read_data`  in  8  FIFO output byte
- `fifo_read_strobe`  out  1  one-cycle FIFO pop
- `tx_ready`  in  1  transmitter idle
- `tx_data`  out  8  byte to transmitter, registered
- `tx_strobe`  out  1  one-cycle send request, registered
- `busy`  out  1  byte in flight (WAIT_DATA, SEND or HOLD)
- `sent_count`  out  COUNT_W  bytes sent, wraps modulo 2^COUNT_W

## Operation
- States: IDLE, ARM, WAIT_DATA, SEND, HOLD.
- IDLE: `enable`=1 -> ARM.
- ARM:
  - `enable`=0 -> IDLE.
  - Else `fifo_read_strobe` = `fifo_available` & `tx_ready` & !`fifo_write_pending` & pace_zero. This is combinational from the state register and inputs, so it is never high in a cycle where `fifo_write_pending` is high.
  - When the strobe is asserted -> WAIT_DATA. Otherwise stay in ARM.
- WAIT_DATA:
  - Latency counter runs READ_LATENCY cycles.
  - On its last cycle, capture `fifo_read_data` into `tx_data` -> SEND.
- SEND:
  - `tx_strobe`=1 for exactly one cycle.
  - Load pace counter with `interval`, sampled this cycle.
  - Increment `sent_count`.
  - -> HOLD.
- HOLD: one cycle with `tx_ready` ignored, to cover transmitter ready lag. Then -> ARM if `enable`, else IDLE.
- `enable` deasserted in WAIT_DATA, SEND or HOLD does not abort. The byte completes first.
- Pace counter:
  - Decrements by 1 per cycle, saturating at 0.
  - pace_zero = (counter == 0).
  - A new `interval` value takes effect only at the next SEND.
- `tx_data` holds its value until the next capture.
- Byte ordering is strictly FIFO order. No byte is read without being sent, except on reset.

## Timing
- Reset values: state IDLE; `tx_data`=0, `tx_strobe`=0, `busy`=0, `sent_count`=0, pace counter 0. `fifo_read_strobe`=0 whenever the state is not ARM.
- Strobe in cycle 0 -> data sampled at the end of cycle READ_LATENCY -> `tx_strobe` high in cycle READ_LATENCY+1.
- Minimum spacing between consecutive `tx_strobe`: max(`interval`, 2) + READ_LATENCY + 1 cycles.
- `fifo_write_pending` held high stalls in ARM indefinitely. The read issues in the first cycle it is low, provided the other conditions hold.
- FIFO empty: wait in ARM, no strobe, no underflow.
- `tx_ready` low in ARM: wait. It is not checked again after the read is issued.
- Reset asserted mid-operation: immediate return to reset values. A byte already popped is discarded and no `tx_strobe` follows.
- `sent_count` at 2^COUNT_W-1 wraps to 0 on the next SEND.

## Structure
- State encodings go in `common/util.v` as shared localparams, so that debug LEDs and GPIO probes in other demos can decode them.
- One natural sub-module: `pace_timer`. It is a loadable, saturating down-counter with a zero flag, and is reusable for LED blink pacing.
- The latency counter and the FSM stay inline.

## Test plan
- Reset: hold `reset_n`=0 with inputs toggling -> every output 0, `fifo_read_strobe` never high.
- Single byte, READ_LATENCY=1, `interval`=0, FIFO holds 0x41, `tx_ready`=1 -> `fifo_read_strobe` in cycle 0; `tx_strobe` with `tx_data`=0x41 in cycle 2; `sent_count`=1.
- Write conflict: `fifo_write_pending` high for cycles 0..4 while in ARM with data available -> no strobe in cycles 0..4; strobe in cycle 5.
- Pacing: `interval`=100, READ_LATENCY=1, bytes 0x01,0x02,0x03 queued -> consecutive `tx_strobe` exactly 102 cycles apart, bytes in order.
- Enable drop: `enable`=0 in the cycle after the read strobe, READ_LATENCY=2 -> `tx_strobe` still occurs in cycle 3, then IDLE; no further reads with data available.
- Abort and wrap:
  - Assert `reset_n`=0 during WAIT_DATA -> no `tx_strobe`.
  - Separately, COUNT_W=4 after 16 sends -> `sent_count`=0.
